// File: rtl/uart_game_decoder.sv
// Receive side of the game-state UART link: pops RX FIFO bytes, reassembles 4-byte packets
// and keeps registered copies of the remote player and boss state.
module uart_game_decoder #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_empty,
    output logic                  rd_uart,
    output logic [11:0]           rem_char_x,
    output logic [11:0]           rem_char_y,
    output logic [3:0]            rem_char_hp,
    output logic                  rem_on_ground,
    output logic [11:0]           rem_boss_x,
    output logic [11:0]           rem_boss_y,
    output logic [6:0]            rem_boss_hp,
    output logic                  pkt_valid,
    output logic [2:0]            pkt_type,
    output logic                  frame_err
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] TypeCharPos = 3'd0;
    localparam logic [2:0] TypeCharHp  = 3'd1;
    localparam logic [2:0] TypeBossPos = 3'd2;
    localparam logic [2:0] TypeBossHp  = 3'd3;
    localparam logic [2:0] TypeStatus  = 3'd4;

    typedef enum logic [1:0] {StHdr, StD1, StD2, StD3} state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [2:0]            type_q;
    logic [DATA_WIDTH-1:0] d1_q;
    logic [DATA_WIDTH-1:0] d2_q;
    logic [23:0]           data;
    logic                  hdr_ok;

    // Every state accepts a byte, so a pop happens whenever the FIFO has data.
    assign rd_uart = !rx_empty;
    assign data    = {d1_q, d2_q, rx_data};
    assign hdr_ok  = !rx_data[7] && (rx_data[3:0] == 4'b0000) && (rx_data[6:4] <= TypeStatus);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StHdr;
            cnt_q         <= '0;
            type_q        <= '0;
            d1_q          <= '0;
            d2_q          <= '0;
            rem_char_x    <= '0;
            rem_char_y    <= '0;
            rem_char_hp   <= '0;
            rem_on_ground <= 1'b0;
            rem_boss_x    <= '0;
            rem_boss_y    <= '0;
            rem_boss_hp   <= '0;
            pkt_valid     <= 1'b0;
            pkt_type      <= '0;
            frame_err     <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state_q)
                StHdr: begin
                    cnt_q <= '0;
                    if (rd_uart) begin
                        if (hdr_ok) begin
                            type_q  <= rx_data[6:4];
                            state_q <= StD1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                StD1, StD2, StD3: begin
                    // A pop in the same cycle as the timeout wins.
                    if (rd_uart) begin
                        cnt_q <= '0;
                        case (state_q)
                            StD1: begin
                                d1_q    <= rx_data;
                                state_q <= StD2;
                            end
                            StD2: begin
                                d2_q    <= rx_data;
                                state_q <= StD3;
                            end
                            default: begin
                                state_q   <= StHdr;
                                pkt_valid <= 1'b1;
                                pkt_type  <= type_q;
                                case (type_q)
                                    TypeCharPos: begin
                                        rem_char_x <= data[23:12];
                                        rem_char_y <= data[11:0];
                                    end
                                    TypeCharHp:  rem_char_hp <= data[3:0];
                                    TypeBossPos: begin
                                        rem_boss_x <= data[23:12];
                                        rem_boss_y <= data[11:0];
                                    end
                                    TypeBossHp:  rem_boss_hp <= data[6:0];
                                    TypeStatus:  rem_on_ground <= data[0];
                                    default: ;
                                endcase
                            end
                        endcase
                    end else if (cnt_q == CntLast) begin
                        cnt_q     <= '0;
                        state_q   <= StHdr;
                        frame_err <= 1'b1;
                        d1_q      <= '0;
                        d2_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StHdr;
            endcase
        end
    end

endmodule
